// File: rtl/coin_credit_fsm.sv
// coin_credit_fsm: vending credit stage; accepts coins, arbitrates select/cancel, drives dispense handshake, pays change
//   in : clk, reset (async active-low), coin_valid, coin_value[1:0], price[WIDTH-1:0], select, cancel, dispense_ack
//   out: credit[WIDTH-1:0], dispense_req, change_pulse, coin_reject, insufficient, busy (all registered)
module coin_credit_fsm #(
  parameter int WIDTH       = 8,
  parameter int MAX_CREDIT  = 200,
  parameter int CHANGE_UNIT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin_valid,
  input  logic [1:0]       coin_value,
  input  logic [WIDTH-1:0] price,
  input  logic             select,
  input  logic             cancel,
  input  logic             dispense_ack,
  output logic [WIDTH-1:0] credit,
  output logic             dispense_req,
  output logic             change_pulse,
  output logic             coin_reject,
  output logic             insufficient,
  output logic             busy
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;
  localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_CREDIT);
  localparam logic [WIDTH-1:0] UNIT_W = WIDTH'(CHANGE_UNIT);
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] credit_q, credit_d, price_q, price_d;
  logic             req_q, req_d, pulse_q, pulse_d, reject_q, reject_d, insuf_q, insuf_d, busy_q, busy_d;
  logic [WIDTH:0]   coin_amt, coin_sum;
  logic             coin_ok;
  // Sum is one bit wider than credit so an over-limit coin can never wrap into range.
  always_comb begin
    coin_amt = coin_value == 2'd0 ? (WIDTH+1)'(5)  :
               coin_value == 2'd1 ? (WIDTH+1)'(10) :
               coin_value == 2'd2 ? (WIDTH+1)'(25) : (WIDTH+1)'(50);
    coin_sum = {1'b0, credit_q} + coin_amt;
    coin_ok  = coin_valid && (state_q == S_IDLE || state_q == S_CREDIT) && !select && !cancel && coin_sum <= MAX_W;
  end
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    req_d    = req_q;
    pulse_d  = 1'b0;
    reject_d = coin_valid && !coin_ok;
    insuf_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coin_ok) begin
          state_d  = S_CREDIT;
          credit_d = coin_sum[WIDTH-1:0];
        end else if (select && !cancel) begin
          insuf_d = 1'b1;
        end
      end
      S_CREDIT: begin
        if (cancel) begin
          state_d = S_CHANGE;
        end else if (select) begin
          if (price != '0 && credit_q >= price) begin
            price_d = price;
            req_d   = 1'b1;
            state_d = S_VEND;
          end else begin
            insuf_d = 1'b1;
          end
        end else if (coin_ok) begin
          credit_d = coin_sum[WIDTH-1:0];
        end
      end
      S_VEND: begin
        if (dispense_ack) begin
          credit_d = credit_q - price_q;
          req_d    = 1'b0;
          state_d  = credit_d != '0 ? S_CHANGE : S_IDLE;
        end
      end
      default: begin
        // A residual below one unit cannot be paid out, so it is dropped.
        pulse_d  = credit_q >= UNIT_W;
        credit_d = pulse_d ? credit_q - UNIT_W : '0;
        state_d  = credit_d == '0 ? S_IDLE : S_CHANGE;
      end
    endcase
    busy_d = state_d == S_VEND || state_d == S_CHANGE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      price_q  <= '0;
      req_q    <= 1'b0;
      pulse_q  <= 1'b0;
      reject_q <= 1'b0;
      insuf_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      req_q    <= req_d;
      pulse_q  <= pulse_d;
      reject_q <= reject_d;
      insuf_q  <= insuf_d;
      busy_q   <= busy_d;
    end
  end
  assign credit       = credit_q;
  assign dispense_req = req_q;
  assign change_pulse = pulse_q;
  assign coin_reject  = reject_q;
  assign insufficient = insuf_q;
  assign busy         = busy_q;
endmodule
